// File: rtl/ctrl_pkg.sv
// Shared types for the accumulator-machine control unit: FSM states,
// instruction opcodes and ALU operation codes.
package ctrl_pkg;

    localparam int OPCODE_W = 3;
    localparam int ALU_OP_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LDA = 3'b000,
        OP_STA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;

    // Maps an arithmetic/logic opcode onto the ALU function select.
    function automatic logic [ALU_OP_W-1:0] alu_op_for(input logic [OPCODE_W-1:0] op);
        logic [ALU_OP_W-1:0] result;
        case (opcode_t'(op))
            OP_SUB:  result = ALU_SUB;
            OP_AND:  result = ALU_AND;
            default: result = ALU_ADD;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational classification of the instruction opcode into the
// groups the control FSM branches on.
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic                is_mem,
    output logic                is_alu,
    output logic                is_load,
    output logic                is_store,
    output logic                is_branch,
    output logic                is_jump,
    output logic                is_halt
);

    always_comb begin
        is_mem    = 1'b0;
        is_alu    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_halt   = 1'b0;
        case (opcode_t'(opcode))
            OP_LDA: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_STA: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
                is_mem = 1'b1;
                is_alu = 1'b1;
            end
            OP_JMP: begin
                is_branch = 1'b1;
                is_jump   = 1'b1;
            end
            OP_JZ:   is_branch = 1'b1;
            OP_HLT:  is_halt   = 1'b1;
            default: is_halt   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit for a 12-bit-address accumulator machine: sequences
// fetch, decode, memory access and ALU execute, and drives datapath enables.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                acc_zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                adr_from_ir,
    output logic                ir_we,
    output logic                pc_we,
    output logic                acc_we,
    output logic                mdr_we,
    output logic                pc_sel_inc,
    output logic                pc_sel_branch,
    output logic                pc_sel_jump,
    output logic                acc_sel_alu,
    output logic                acc_sel_mem,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted
);

    state_t state;

    logic is_mem;
    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_halt;

    opcode_decoder u_decoder (
        .opcode    (opcode),
        .is_mem    (is_mem),
        .is_alu    (is_alu),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_halt   (is_halt)
    );

    // Only the state is registered; enables that depend on mem_ack must fire
    // in the acknowledge cycle itself, so outputs are decoded combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state <= ST_FETCH;
                ST_FETCH:  if (mem_ack) state <= ST_DECODE;
                ST_DECODE: begin
                    if (is_mem)
                        state <= ST_MEM;
                    else if (is_halt)
                        state <= ST_HALT;
                    else
                        state <= ST_FETCH;
                end
                ST_MEM:    if (mem_ack) state <= is_alu ? ST_EXEC : ST_FETCH;
                ST_EXEC:   state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_from_ir   = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        acc_we        = 1'b0;
        mdr_we        = 1'b0;
        pc_sel_inc    = 1'b0;
        pc_sel_branch = 1'b0;
        pc_sel_jump   = 1'b0;
        acc_sel_alu   = 1'b0;
        acc_sel_mem   = 1'b0;
        alu_op        = ALU_ADD;
        halted        = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    pc_sel_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_jump) begin
                    pc_we       = 1'b1;
                    pc_sel_jump = 1'b1;
                end else if (is_branch && acc_zero) begin
                    pc_we         = 1'b1;
                    pc_sel_branch = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                adr_from_ir = 1'b1;
                mem_we      = is_store;
                if (mem_ack) begin
                    if (is_load) begin
                        acc_we      = 1'b1;
                        acc_sel_mem = 1'b1;
                    end else if (is_alu) begin
                        mdr_we = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                acc_we      = 1'b1;
                acc_sel_alu = 1'b1;
                alu_op      = alu_op_for(opcode);
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table of per-instruction vectors
// plus hand-written reset, halt and random select-legality sequences.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic       acc_zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, adr_from_ir, ir_we, pc_we, acc_we, mdr_we;
    logic       pc_sel_inc, pc_sel_branch, pc_sel_jump, acc_sel_alu, acc_sel_mem;
    logic [1:0] alu_op;
    logic       halted;

    int errors = 0;
    int checks = 0;

    localparam logic [14:0] B_REQ   = 15'h4000;
    localparam logic [14:0] B_ADR   = 15'h1000;
    localparam logic [14:0] B_IR    = 15'h0800;
    localparam logic [14:0] B_PCWE  = 15'h0400;
    localparam logic [14:0] B_ACCWE = 15'h0200;
    localparam logic [14:0] B_INC   = 15'h0080;
    localparam logic [14:0] B_MSEL  = 15'h0008;
    localparam logic [14:0] B_HALT  = 15'h0001;

    typedef struct {
        logic [2:0] op;
        logic       az;
        int         fdly;
        int         mdly;
        int         exp_cycles;
        logic [7:0] exp_seen;
        logic [1:0] exp_alu;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .acc_zero      (acc_zero),
        .mem_ack       (mem_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .adr_from_ir   (adr_from_ir),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .acc_we        (acc_we),
        .mdr_we        (mdr_we),
        .pc_sel_inc    (pc_sel_inc),
        .pc_sel_branch (pc_sel_branch),
        .pc_sel_jump   (pc_sel_jump),
        .acc_sel_alu   (acc_sel_alu),
        .acc_sel_mem   (acc_sel_mem),
        .alu_op        (alu_op),
        .halted        (halted)
    );

    a_pc_sel: assert property (@(posedge clk) disable iff (!rst_n)
        (pc_we ? $onehot({pc_sel_inc, pc_sel_branch, pc_sel_jump})
               : ({pc_sel_inc, pc_sel_branch, pc_sel_jump} == 3'b000)))
        else begin
            errors++;
            $display("[TB] FAIL a_pc_sel: pc_we=%0b sel=%b", pc_we, {pc_sel_inc, pc_sel_branch, pc_sel_jump});
        end

    a_acc_sel: assert property (@(posedge clk) disable iff (!rst_n)
        (acc_we ? $onehot({acc_sel_alu, acc_sel_mem})
                : ({acc_sel_alu, acc_sel_mem} == 2'b00)))
        else begin
            errors++;
            $display("[TB] FAIL a_acc_sel: acc_we=%0b sel=%b", acc_we, {acc_sel_alu, acc_sel_mem});
        end

    function automatic logic [14:0] outs();
        return {mem_req, mem_we, adr_from_ir, ir_we, pc_we, acc_we, mdr_we,
                pc_sel_inc, pc_sel_branch, pc_sel_jump, acc_sel_alu, acc_sel_mem,
                alu_op, halted};
    endfunction

    function automatic bit selects_legal();
        logic [2:0] pcs;
        logic [1:0] accs;
        pcs  = {pc_sel_inc, pc_sel_branch, pc_sel_jump};
        accs = {acc_sel_alu, acc_sel_mem};
        return (pc_we ? $onehot(pcs) : (pcs == 3'b000)) &&
               (acc_we ? $onehot(accs) : (accs == 2'b00)) &&
               (!mem_we || (mem_req && adr_from_ir));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ends at negedge+1 of the first FETCH cycle with mem_ack low.
    task automatic do_reset();
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_outs", 32'(outs()), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        checkOutput("idle_after_reset", 32'(outs()), 32'h0);
        @(negedge clk); #1;
        checkOutput("fetch_entry", 32'(outs()), 32'(B_REQ));
    endtask

    // Runs one instruction from its first FETCH cycle; returns at the next
    // FETCH (or HALT) cycle, again at negedge+1 with mem_ack low.
    task automatic applyStimulus(input logic [2:0] op, input logic az, input int fdly, input int mdly,
                                 output int cycles, output logic [7:0] seen,
                                 output logic [1:0] alu_seen, output int inc_cnt);
        int wait_cnt;
        bit left_fetch;
        bit fetch_like;
        bit mem_like;
        wait_cnt   = 0;
        left_fetch = 1'b0;
        cycles     = 0;
        seen       = 8'h00;
        alu_seen   = 2'b00;
        inc_cnt    = 0;
        opcode     = op;
        acc_zero   = az;
        while (cycles < 40) begin
            fetch_like = mem_req && !adr_from_ir;
            mem_like   = mem_req && adr_from_ir;
            if (left_fetch && (fetch_like || halted)) break;
            if (fetch_like || mem_like) begin
                if (wait_cnt == (mem_like ? mdly : fdly)) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            #1;
            seen |= {adr_from_ir, pc_we & pc_sel_jump, pc_we & pc_sel_branch,
                     acc_we & acc_sel_alu, acc_we & acc_sel_mem, mdr_we, mem_we, ir_we};
            if (acc_sel_alu) alu_seen = alu_op;
            if (pc_sel_inc) inc_cnt++;
            if (!fetch_like) left_fetch = 1'b1;
            cycles++;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(negedge clk); #1;
        end
        checks++;
        if (cycles >= 40) begin
            errors++;
            $display("[TB] FAIL instr_timeout: op=%0d ran %0d cycles, limit 40", op, cycles);
        end
    endtask

    initial begin
        int         cyc;
        logic [7:0] seen;
        logic [1:0] alu_seen;
        int         inc_cnt;

        vecs[0]  = '{OP_LDA, 1'b0, 0, 0, 3, 8'h89, 2'b00};
        vecs[1]  = '{OP_STA, 1'b0, 0, 0, 3, 8'h83, 2'b00};
        vecs[2]  = '{OP_ADD, 1'b0, 0, 0, 4, 8'h95, 2'b00};
        vecs[3]  = '{OP_SUB, 1'b0, 1, 2, 7, 8'h95, 2'b01};
        vecs[4]  = '{OP_AND, 1'b1, 0, 1, 5, 8'h95, 2'b10};
        vecs[5]  = '{OP_JMP, 1'b0, 0, 0, 2, 8'h41, 2'b00};
        vecs[6]  = '{OP_JZ,  1'b1, 2, 0, 4, 8'h21, 2'b00};
        vecs[7]  = '{OP_JZ,  1'b0, 0, 0, 2, 8'h01, 2'b00};
        vecs[8]  = '{OP_LDA, 1'b1, 2, 3, 8, 8'h89, 2'b00};
        vecs[9]  = '{OP_STA, 1'b0, 0, 3, 6, 8'h83, 2'b00};
        vecs[10] = '{OP_ADD, 1'b0, 0, 3, 7, 8'h95, 2'b00};
        vecs[11] = '{OP_JMP, 1'b1, 1, 5, 3, 8'h41, 2'b00};
        vecs[12] = '{OP_HLT, 1'b0, 0, 0, 2, 8'h01, 2'b00};

        #2;
        // Ack tied high from reset onwards with LDA on the opcode lines.
        opcode   = OP_LDA;
        acc_zero = 1'b0;
        mem_ack  = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_hold_ack_high", 32'(outs()), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        checkOutput("c1_idle", 32'(outs()), 32'h0);
        @(negedge clk); #1;
        checkOutput("c2_fetch_ack", 32'(outs()), 32'(B_REQ | B_IR | B_PCWE | B_INC));
        @(negedge clk); #1;
        checkOutput("c3_decode_lda", 32'(outs()), 32'h0);
        @(negedge clk); #1;
        checkOutput("c4_mem_lda", 32'(outs()), 32'(B_REQ | B_ADR | B_ACCWE | B_MSEL));
        @(negedge clk); #1;
        checkOutput("c5_fetch_again", 32'(outs()), 32'(B_REQ | B_IR | B_PCWE | B_INC));

        do_reset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].az, vecs[i].fdly, vecs[i].mdly, cyc, seen, alu_seen, inc_cnt);
            checkOutput($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
            checkOutput($sformatf("v%0d_enables", i), 32'(seen), 32'(vecs[i].exp_seen));
            checkOutput($sformatf("v%0d_alu_op", i), 32'(alu_seen), 32'(vecs[i].exp_alu));
            checkOutput($sformatf("v%0d_pc_inc_count", i), 32'(inc_cnt), 32'd1);
        end

        // Now in HALT: ack pulses and opcode changes must be ignored.
        opcode = OP_LDA;
        for (int i = 0; i < 6; i++) begin
            mem_ack = i[0];
            #1;
            checkOutput($sformatf("halt_hold%0d", i), 32'(outs()), 32'(B_HALT));
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(negedge clk); #1;
        end

        // Reset pulse in the middle of an LDA memory access.
        do_reset();
        opcode  = OP_LDA;
        mem_ack = 1'b1;
        #1;
        checkOutput("abort_fetch", 32'(outs()), 32'(B_REQ | B_IR | B_PCWE | B_INC));
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk); #1;
        checkOutput("abort_decode", 32'(outs()), 32'h0);
        @(negedge clk); #1;
        checkOutput("abort_mem_wait", 32'(outs()), 32'(B_REQ | B_ADR));
        mem_ack = 1'b1;
        rst_n   = 1'b0;
        #1;
        checkOutput("abort_immediate", 32'(outs()), 32'h0);
        @(posedge clk); #1;
        checkOutput("abort_held", 32'(outs()), 32'h0);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk); #1;
        checkOutput("abort_idle", 32'(outs()), 32'h0);
        @(negedge clk); #1;
        checkOutput("abort_refetch", 32'(outs()), 32'(B_REQ));

        // Random opcode/ack stream, avoiding HLT so the FSM keeps cycling.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            opcode   = 3'($urandom_range(0, 6));
            acc_zero = 1'($urandom_range(0, 1));
            mem_ack  = 1'($urandom_range(0, 1));
            #1;
            checkOutput("rand_selects_legal", 32'(selects_legal()), 32'd1);
            checkOutput("rand_not_halted", 32'(halted), 32'd0);
            @(negedge clk); #1;
        end
        mem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: `clk` and `rst_n`.
REQ-002 The port list SHALL be, in order:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  3  IR[15:13] from datapath
- `acc_zero`  in  1  high when accumulator == 0
- `mem_ack`  in  1  memory completes current request; sampled on `clk` rising edge
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write (valid with `mem_req`)
- `adr_from_ir`  out  1  memory address = IR[11:0]; else PC
- `ir_we`, `pc_we`, `acc_we`, `mdr_we`  out  1 each  register write enables
- `pc_sel_inc`, `pc_sel_branch`, `pc_sel_jump`  out  1 each  one-hot selects for 12-bit 3:1 PC mux
- `acc_sel_alu`, `acc_sel_mem`  out  1 each  one-hot selects for 8-bit 2:1 acc mux
- `alu_op`  out  2  00 ADD, 01 SUB, 10 AND
- `halted`  out  1  high in HALT

Function
REQ-003 Opcodes SHALL be:
- 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 JMP, 110 JZ, 111 HLT.
REQ-004 States SHALL be IDLE, FETCH, DECODE, MEM, EXEC, HALT.
REQ-005 Outputs SHALL be Moore/Mealy decodes of state plus `mem_ack`/`opcode`/`acc_zero`, and SHALL all be 0 unless stated.
REQ-006 IDLE SHALL drive all outputs 0 and go to FETCH after one cycle.
REQ-007 FETCH behaviour:
- drives `mem_req`=1, `adr_from_ir`=0
- while `mem_ack`=0: holds in FETCH
- on `mem_ack`=1: drives `ir_we`=1, `pc_we`=1, `pc_sel_inc`=1, then goes to DECODE
REQ-008 DECODE SHALL last exactly one cycle and branch on `opcode`:
- LDA/STA/ADD/SUB/AND: go to MEM
- JMP: `pc_we`=1, `pc_sel_jump`=1, go to FETCH
- JZ with `acc_zero`=1: `pc_we`=1, `pc_sel_branch`=1, go to FETCH
- JZ with `acc_zero`=0: no write, go to FETCH
- HLT: go to HALT
REQ-009 MEM behaviour:
- drives `mem_req`=1, `adr_from_ir`=1, `mem_we`=(opcode==STA)
- holds until `mem_ack`
- on ack, LDA: `acc_we`=1, `acc_sel_mem`=1, go to FETCH
- on ack, STA: go to FETCH
- on ack, ALU ops: `mdr_we`=1, go to EXEC
REQ-010 EXEC SHALL drive `acc_we`=1, `acc_sel_alu`=1 and `alu_op` (ADD→00, SUB→01, AND→10) for one cycle, then go to FETCH.
REQ-011 HALT SHALL drive `halted`=1 and no other output, and SHALL be left only by reset.
REQ-012 Latency with `mem_ack` high in the first request cycle SHALL be:
- JMP/JZ/HLT-entry: 2 cycles
- LDA/STA: 3 cycles
- ADD/SUB/AND: 4 cycles
- each cycle of ack delay in FETCH or MEM adds one cycle.
REQ-013 Select groups SHALL never be multi-hot:
- PC selects SHALL be all-zero whenever `pc_we`=0.
- Acc selects SHALL be all-zero whenever `acc_we`=0.
REQ-014 `mem_ack` SHALL be ignored in IDLE, DECODE, EXEC and HALT.
REQ-015 `opcode` SHALL be sampled only in DECODE, MEM and EXEC; the datapath holds IR stable after `ir_we`.

Reset
REQ-016 Asserting `rst_n`=0 at any time, including mid-request, SHALL immediately force state to IDLE and all outputs to 0; no handshake completes.
REQ-017 After `rst_n` deassertion, the first `mem_req` SHALL appear in the second rising edge's cycle (IDLE→FETCH).

Structure
REQ-018 Package `ctrl_pkg` SHALL hold:
- state enum
- opcode enum/localparams
- `alu_op` codes
REQ-019 Opcode classification (is_mem, is_alu, is_store, is_branch) SHALL live in combinational sub-module `opcode_decoder`; FSM and output decode stay in `multicycle_controller`.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, release, ack tied high, opcode=LDA → `mem_req` in cycle 2; `ir_we`+`pc_sel_inc` cycle 2; `acc_we`+`acc_sel_mem`+`adr_from_ir` cycle 4.
- ADD with `mem_ack` delayed 3 cycles in MEM → `mdr_we` on the ack cycle; `acc_sel_alu`, `alu_op`=00 next cycle; instruction totals 7 cycles.
- JZ with `acc_zero`=1 then 0 → `pc_sel_branch`+`pc_we` in DECODE first time only; never `pc_sel_inc` in DECODE.
- STA → `mem_we`=1 only during MEM; no `acc_we`; back to FETCH.
- HLT then ack pulses → `halted`=1 stays; no `mem_req`; `rst_n` pulse mid-MEM of an LDA → all outputs 0 at once, no `acc_we`.
- Random opcode/ack stream (assertions) → no multi-hot select group; selects zero when the matching enable is 0.
